// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core hazard logic.
// Includes forwarding select codes, pipeline slot structs and the write-match helper.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  load;
  } slot_t;

  // The execute slot additionally remembers its source registers for forwarding.
  typedef struct packed {
    slot_t                 info;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } e_slot_t;

  // A slot produces register r only if it is live, writes, and r is not x0.
  function automatic logic writes(slot_t s, logic [REG_ADDR_W-1:0] r);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline shadow slot: holds while the pipe is frozen, loads a bubble on
// request, and clears asynchronously on reset.
module hazard_slot #(
  parameter type T = riscv_pkg::slot_t
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic bubble,
  input  T     d,
  output T     q
);

  // NOTE: sequential state uses non-blocking assignment so every slot samples
  // the pre-edge value of its upstream neighbour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? T'('0) : d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/flush/forward controller driven by registered E, M, W shadow slots.
// Optional macro FORWARD_EN enables E-operand forwarding; otherwise dependencies stall.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rd_D,
  input  logic                  RegWrite_D,
  input  logic                  ResultSrc_D,
  input  logic                  PCSrc_E,
  input  logic                  Mem_Busy,
  output logic                  Stall_F,
  output logic                  Stall_D,
  output logic                  Stall_E,
  output logic                  Stall_M,
  output logic                  Flush_D,
  output logic                  Flush_E,
  output logic [1:0]            ForwardA_E,
  output logic [1:0]            ForwardB_E,
  output logic [CNT_W-1:0]      Stall_Count
);

  e_slot_t d_info;
  e_slot_t e_q;
  slot_t   m_q;
  slot_t   w_q;

  logic       data_stall;
  logic       stall_fd_raw, stall_em_raw, flush_d_raw, flush_e_raw;
  logic [1:0] fwd_a, fwd_b;
  logic       unused_slot_bits;

  logic [CNT_W-1:0] stall_cnt;

  assign d_info = '{
    info: '{valid: 1'b1, rd: Rd_D, regwrite: RegWrite_D, load: ResultSrc_D},
    rs1:  Rs1_D,
    rs2:  Rs2_D
  };

  hazard_slot #(.T(e_slot_t)) u_slot_e (
    .clk    (clk),
    .rst    (rst),
    .hold   (Mem_Busy),
    .bubble (flush_e_raw | stall_fd_raw),
    .d      (d_info),
    .q      (e_q)
  );

  hazard_slot #(.T(slot_t)) u_slot_m (
    .clk    (clk),
    .rst    (rst),
    .hold   (Mem_Busy),
    .bubble (1'b0),
    .d      (e_q.info),
    .q      (m_q)
  );

  hazard_slot #(.T(slot_t)) u_slot_w (
    .clk    (clk),
    .rst    (rst),
    .hold   (Mem_Busy),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

`ifdef FORWARD_EN
  // Only a load in E cannot be forwarded in time; everything else bypasses.
  assign data_stall = e_q.info.load &&
                      (writes(e_q.info, Rs1_D) || writes(e_q.info, Rs2_D));

  assign fwd_a = writes(m_q, e_q.rs1) ? FWD_MEM :
                 writes(w_q, e_q.rs1) ? FWD_WB  : FWD_NONE;
  assign fwd_b = writes(m_q, e_q.rs2) ? FWD_MEM :
                 writes(w_q, e_q.rs2) ? FWD_WB  : FWD_NONE;

  assign unused_slot_bits = m_q.load ^ w_q.load;
`else
  // Without bypass or register-file write-through, D waits until the producer retires.
  assign data_stall = writes(e_q.info, Rs1_D) || writes(e_q.info, Rs2_D) ||
                      writes(m_q, Rs1_D)      || writes(m_q, Rs2_D)      ||
                      writes(w_q, Rs1_D)      || writes(w_q, Rs2_D);

  assign fwd_a = FWD_NONE;
  assign fwd_b = FWD_NONE;

  assign unused_slot_bits = ^{e_q.rs1, e_q.rs2, e_q.info.load, m_q.load, w_q.load};
`endif

  // NOTE: every combinational output gets a default before the priority chain,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stall_fd_raw = 1'b0;
    stall_em_raw = 1'b0;
    flush_d_raw  = 1'b0;
    flush_e_raw  = 1'b0;
    if (Mem_Busy) begin
      stall_fd_raw = 1'b1;
      stall_em_raw = 1'b1;
    end else if (PCSrc_E) begin
      flush_d_raw = 1'b1;
      flush_e_raw = 1'b1;
    end else if (data_stall) begin
      stall_fd_raw = 1'b1;
      flush_e_raw  = 1'b1;
    end
  end

  // Outputs are forced idle while reset is held; slot/counter paths use the
  // raw controls since those registers are cleared anyway.
  assign Stall_F    = rst & stall_fd_raw;
  assign Stall_D    = rst & stall_fd_raw;
  assign Stall_E    = rst & stall_em_raw;
  assign Stall_M    = rst & stall_em_raw;
  assign Flush_D    = rst & flush_d_raw;
  assign Flush_E    = rst & flush_e_raw;
  assign ForwardA_E = rst ? fwd_a : FWD_NONE;
  assign ForwardB_E = rst ? fwd_b : FWD_NONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_fd_raw && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign Stall_Count = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected controls are queued per step
// and compared at the following negedge; follows the FORWARD_EN build setting.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  import riscv_pkg::*;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic       sf, sd, se, sm, fd, fe;
    logic [1:0] fa, fb;
  } exp_t;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_STL  = 6'b110001;
  localparam logic [5:0] C_BR   = 6'b000011;
  localparam logic [5:0] C_BUSY = 6'b111100;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REG_ADDR_W-1:0] Rs1_D, Rs2_D, Rd_D;
  logic                  RegWrite_D, ResultSrc_D, PCSrc_E, Mem_Busy;
  logic                  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
  logic [1:0]            ForwardA_E, ForwardB_E;
  logic [CNT_W-1:0]      Stall_Count;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] cnt_q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .Rd_D        (Rd_D),
    .RegWrite_D  (RegWrite_D),
    .ResultSrc_D (ResultSrc_D),
    .PCSrc_E     (PCSrc_E),
    .Mem_Busy    (Mem_Busy),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Stall_E     (Stall_E),
    .Stall_M     (Stall_M),
    .Flush_D     (Flush_D),
    .Flush_E     (Flush_E),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .Stall_Count (Stall_Count)
  );

  function automatic exp_t mk(input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    {e.sf, e.sd, e.se, e.sm, e.fd, e.fe} = ctl;
    e.fa = fa;
    e.fb = fb;
    return e;
  endfunction

  // Drives one decode-stage cycle, queues its expectation, checks at negedge.
  task automatic step(input string tag,
                      input logic [REG_ADDR_W-1:0] rs1, input logic [REG_ADDR_W-1:0] rs2,
                      input logic [REG_ADDR_W-1:0] rd, input logic rw, input logic ld,
                      input logic pc, input logic busy, input exp_t e);
    exp_t             got, want;
    logic [CNT_W-1:0] want_cnt;
    Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd;
    RegWrite_D = rw; ResultSrc_D = ld; PCSrc_E = pc; Mem_Busy = busy;
    exp_q.push_back(e);
    cnt_q.push_back(exp_cnt);
    @(negedge clk);
    want     = exp_q.pop_front();
    want_cnt = cnt_q.pop_front();
    got = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, ForwardA_E, ForwardB_E};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s ctl: observed %b expected %b", tag, got, want);
    end
    checks++;
    assert (Stall_Count === want_cnt) else begin
      errors++;
      $error("FAIL %s count: observed %0d expected %0d", tag, Stall_Count, want_cnt);
    end
    if (want.sd && rst && (exp_cnt != '1)) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; exp_cnt = '0;
    Rs1_D = '0; Rs2_D = '0; Rd_D = '0;
    RegWrite_D = 1'b0; ResultSrc_D = 1'b0; PCSrc_E = 1'b0; Mem_Busy = 1'b0;
    @(posedge clk); #1;

    // Reset holds every output low, even with branch and busy asserted.
    step("rst_idle",  0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("rst_force", 3, 3, 3, 1, 1, 1, 1, mk(C_NONE, 2'b00, 2'b00));
    step("rst_idle2", 0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    rst = 1'b1;
    step("idle",      0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));

    // Load-use: lw x5 then a consumer of x5.
    step("lu_lw",     0, 0, 5, 1, 1, 0, 0, mk(C_NONE, 2'b00, 2'b00));
`ifdef FORWARD_EN
    step("lu_stall",  5, 0, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("lu_hold",   5, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("lu_fwd",    0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b01, 2'b00));
`else
    step("lu_stall1", 5, 0, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("lu_stall2", 5, 0, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("lu_stall3", 5, 0, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("lu_go",     5, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("lu_after",  0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
`endif
    for (int i = 0; i < 3; i++)
      step("drain1",  0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));

    // ALU chain: add x3, consumer on rs2, then consumer on rs1.
    step("alu_add",   0, 0, 3, 1, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
`ifdef FORWARD_EN
    step("alu_b",     0, 3, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("alu_fwd_b", 3, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b10));
    step("alu_fwd_a", 0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b01, 2'b00));
`else
    step("alu_st1",   0, 3, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("alu_st2",   0, 3, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("alu_st3",   0, 3, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("alu_b_go",  0, 3, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("alu_c",     3, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("alu_after", 0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
`endif
    for (int i = 0; i < 3; i++)
      step("drain2",  0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));

    // Branch taken in the same cycle as a load-use match: branch wins.
    step("br_lw",     0, 0, 7, 1, 1, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("br_vs_lu",  7, 0, 0, 0, 0, 1, 0, mk(C_BR,   2'b00, 2'b00));
    step("br_after",  0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++)
      step("drain3",  0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));

    // Mem_Busy freezes all slots and masks a pending branch.
    step("mb_add",    0, 0, 4, 1, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    for (int i = 0; i < 4; i++)
      step("mb_busy", 4, 0, 0, 0, 0, 1, 1, mk(C_BUSY, 2'b00, 2'b00));
    step("mb_branch", 4, 0, 0, 0, 0, 1, 0, mk(C_BR,   2'b00, 2'b00));
`ifdef FORWARD_EN
    step("mb_dep",    4, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("mb_fwd",    0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b01, 2'b00));
`else
    step("mb_st_m",   4, 0, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("mb_st_w",   4, 0, 0, 0, 0, 0, 0, mk(C_STL,  2'b00, 2'b00));
    step("mb_go",     4, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
`endif
    for (int i = 0; i < 3; i++)
      step("drain4",  0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));

    // x0 is never a hazard source.
    step("x0_lw",     0, 0, 0, 1, 1, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("x0_use",    0, 0, 0, 1, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("x0_use2",   0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));

    // Reset mid-stream drops a load that would otherwise stall its consumer.
    step("mr_lw",     0, 0, 9, 1, 1, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    rst = 1'b0; exp_cnt = '0;
    step("mr_rst",    9, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    rst = 1'b1;
    step("mr_rel",    9, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));
    step("mr_idle",   0, 0, 0, 0, 0, 0, 0, mk(C_NONE, 2'b00, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core (F, D, E, M, W).
- Holds a registered shadow of the destination/source information for the E, M and W stages.
- From that shadow it drives the stall, flush and forwarding controls for the fetch, decode and execute pipeline registers.
- Sits beside the decode-stage register and replaces any ad hoc stall logic in the stages.

Parameters:
- REG_ADDR_W, 5, register address width (x0..x31).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- Rs1_D  in  REG_ADDR_W  rs1 of decode instruction (Instr_D[19:15]).
- Rs2_D  in  REG_ADDR_W  rs2 of decode instruction (Instr_D[24:20]).
- Rd_D  in  REG_ADDR_W  rd of decode instruction (Instr_D[11:7]).
- RegWrite_D  in  1  decode instruction writes rd.
- ResultSrc_D  in  1  decode instruction is a load.
- PCSrc_E  in  1  branch taken, resolved in E.
- Mem_Busy  in  1  data memory not ready; freeze the whole pipe.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold F/D register.
- Stall_E  out  1  hold D/E register.
- Stall_M  out  1  hold E/M and M/W registers.
- Flush_D  out  1  clear F/D register.
- Flush_E  out  1  clear D/E register (bubble).
- ForwardA_E  out  2  operand A select: 00 = RD1_E, 10 = ALU result from M, 01 = result from W.
- ForwardB_E  out  2  operand B select, same encoding as ForwardA_E.
- Stall_Count  out  CNT_W  count of cycles with Stall_D=1; saturating.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0): all slots invalid (valid=0, rd=0, load=0, rs=0); Stall_Count=0.
  - Reset forces every combinational output to 0; ForwardA_E/B_E=00.
  - Reset mid-stream drops all in-flight entries; no stall is asserted on the first cycle after release.
- Slot contents: E, M and W slots each hold valid, rd, regwrite and load; the E slot also holds rs1 and rs2.
- Slot advance on posedge clk when Mem_Busy=0:
  - E <= D info, or a bubble (all zero) if Flush_E=1.
  - M <= E.
  - W <= M.
  - D info is captured only when Stall_D=0; otherwise E receives a bubble.
- When Mem_Busy=1: all slots hold; Stall_F/D/E/M=1; Flush_D/E forced 0.
  - A pending PCSrc_E is re-evaluated when Mem_Busy falls, because E is held.
- Write-match definition: slot S "writes r" iff S.valid & S.regwrite & S.rd!=0 & S.rd==r.
- Load-use hazard: E.load and E writes Rs1_D or Rs2_D.
  - Response: Stall_F=Stall_D=1 and Flush_E=1.
  - Latency: exactly 1 bubble.
- Branch taken (PCSrc_E=1): Flush_D=Flush_E=1.
  - Stall_F=Stall_D=0; the branch overrides a simultaneous load-use.
  - Priority order: Mem_Busy > PCSrc_E > data hazard.
- Forwarding for E operands:
  - ForwardA_E=10 if M writes E.rs1; else 01 if W writes E.rs1; else 00.
  - M has priority over W.
  - ForwardB_E uses E.rs2 with the same rule.
- x0 is never a hazard source: rd=0 never matches.
- Stall_Count increments by 1 on each cycle with Stall_D=1; holds at all-ones.
- All outputs except Stall_Count are combinational from slots and inputs; no output depends on the current clk edge.

Optional Feature:
- Macro FORWARD_EN.
- Defined:
  - Forwarding as specified above.
  - Load-use is the only data stall.
- Undefined:
  - ForwardA_E/B_E tied 00.
  - Data stall (Stall_F=Stall_D=1, Flush_E=1) while any of E, M or W writes Rs1_D or Rs2_D; the register file has no write-through.
  - A dependent back-to-back ALU pair stalls 3 cycles.
  - Branch and Mem_Busy priority unchanged.

Decomposition:
- Shared package (riscv_pkg):
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_ADDR_W.
  - A stage-slot struct {valid, rd, regwrite, load}.
- Natural sub-module: hazard_slot, one pipeline slot register with hold, bubble and async clear; instantiated for E, M and W.
- Remaining hazard/forward logic stays in the top.

Test Plan:
- Reset then idle:
  - Stimulus: rst=0 for 3 cycles, release; RegWrite_D=0.
  - Required: all stall/flush outputs 0, ForwardA_E/B_E=00, Stall_Count=0.
- Load-use:
  - Stimulus: lw x5 (Rd_D=5, ResultSrc_D=1), next Rs1_D=5.
  - Required: one cycle Stall_F=Stall_D=Flush_E=1; next cycle ForwardA_E=01; Stall_Count=1.
- ALU chain, FORWARD_EN defined:
  - Stimulus: add x3, then Rs2_D=3, then Rs1_D=3.
  - Required: no stall; ForwardB_E=10, then ForwardA_E=01.
- ALU chain, FORWARD_EN undefined:
  - Stimulus: same sequence.
  - Required: 3 stall cycles; Forward outputs stay 00; Stall_Count=3.
- Branch vs load-use:
  - Stimulus: PCSrc_E=1 in the same cycle as a load-use match.
  - Required: Flush_D=Flush_E=1, Stall_F=Stall_D=0.
- Mem_Busy and x0:
  - Stimulus: Mem_Busy=1 for 4 cycles with PCSrc_E=1.
  - Required: all stalls 1, flushes 0, slots frozen; flush fires on the first cycle after Mem_Busy=0.
  - Stimulus: Rd_D=0 load, then Rs1_D=0.
  - Required: no stall.
